qpmm_sched: RTL and testbench

- Round-robin issue scheduler that shares one fully pipelined QPMM Montgomery multiplier among NUM_REQ requesters (Fp2/Fp6 arithmetic units).
- The multiplier has a fixed latency and no valid or stall path. This block therefore tracks in-flight slots with a valid/tag shift line, buffers results in a credit-protected FIFO, and returns each result with its requester id and tag.
- Sits between the tower-field sequencers and the external QPMM_d0 instance.

---
 rtl/qpmm_sched_pkg.sv | 28 ++
 rtl/qpmm_res_fifo.sv | 76 +++++++
 rtl/qpmm_res_fifo_chk.sv | 14 +
 rtl/qpmm_sched.sv | 173 +++++++++++++++++
 tb/tb_qpmm_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpmm_sched_pkg.sv
// Shared types and latency constants for the QPMM issue scheduler.
package qpmm_sched_pkg;

  // Multiplier geometry: N digits of D bits each.
  localparam int N          = 16;
  localparam int D          = 16;
  // Per-digit stage latency and final-adder latency of the QPMM datapath.
  localparam int LATENCY    = 3;
  localparam int LATENCY_FA = 4;

  localparam int FP_W = N * D;

  // Cycles from mm_a/mm_b to mm_z.
  localparam int QPMM_LATENCY = LATENCY * (N + D + 1) + LATENCY_FA + 1;

  typedef logic [FP_W-1:0] qpmm_fp_t;

  // Result record layout for the default four-requester, 4-bit-tag setup.
  localparam int SCHED_ID_W  = 2;
  localparam int SCHED_TAG_W = 4;

  typedef struct packed {
    qpmm_fp_t               z;
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_TAG_W-1:0] tag;
  } qpmm_sched_entry_t;

endpackage

// File: rtl/qpmm_res_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads as zero when empty.
module qpmm_res_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  cnt_r;
  logic           pop_s;
  logic           full_s;

  assign pop_s  = pop && (cnt_r != CW'(0));
  assign full_s = (cnt_r == CW'(DEPTH));
  assign valid  = (cnt_r != CW'(0));
  assign count  = cnt_r;

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Show-ahead head entry, forced to zero while the buffer is empty.
  always_comb begin
    if (valid) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = '0;
    end
  end

  qpmm_res_fifo_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop_s),
    .full (full_s)
  );

endmodule

// File: rtl/qpmm_res_fifo_chk.sv
// Protocol checker for the result FIFO: catches writes into a full buffer.
module qpmm_res_fifo_chk (
  input logic clk,
  input logic rstn,
  input logic push,
  input logic pop,
  input logic full
);

  // A push into a full buffer is only legal when a pop frees a slot in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop))
    else $error("qpmm_res_fifo: push into full buffer");

endmodule

// File: rtl/qpmm_sched.sv
// Round-robin issue scheduler sharing one fixed-latency QPMM multiplier.
// A valid/id/tag shift line follows each operand pair through the multiplier
// and a credit-protected FIFO buffers the results for the consumer.
module qpmm_sched
  import qpmm_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int QPMM_LAT   = QPMM_LATENCY,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  qpmm_fp_t                   req_a   [NUM_REQ],
  input  qpmm_fp_t                   req_b   [NUM_REQ],
  input  logic [TAG_W-1:0]           req_tag [NUM_REQ],
  output qpmm_fp_t                   mm_a,
  output qpmm_fp_t                   mm_b,
  input  qpmm_fp_t                   mm_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output qpmm_fp_t                   res_z,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [TAG_W-1:0] tag;
  } meta_t;

  typedef struct packed {
    qpmm_fp_t         z;
    logic [IDW-1:0]   id;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [IDW-1:0]     rr_ptr_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     grant_id_s;
  logic [IDW-1:0]     idx_s;
  logic [IDW:0]       rr_sum_s;
  logic               found_s;
  logic               issue_s;
  logic               credit_ok_s;
  logic [CW:0]        occ_s;
  logic [CW-1:0]      inflight_r;
  logic [CW-1:0]      fifo_cnt_s;
  qpmm_fp_t           mm_a_r;
  qpmm_fp_t           mm_b_r;
  // Slot 0 is captured alongside mm_a; slot QPMM_LAT lines up with mm_z.
  logic [QPMM_LAT:0]  slot_v_r;
  meta_t              slot_m_r [QPMM_LAT+1];
  logic               tail_s;
  logic               pop_s;
  entry_t             push_data_s;
  entry_t             head_s;

  // Credit counts only registered occupancy, so a same-cycle pop frees nothing yet.
  assign occ_s       = {1'b0, inflight_r} + {1'b0, fifo_cnt_s};
  assign credit_ok_s = rstn && (occ_s < (CW+1)'(FIFO_DEPTH));

  // Round-robin search starting at rr_ptr with wrap; at most one grant.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    idx_s      = '0;
    rr_sum_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (rr_sum_s >= (IDW+1)'(NUM_REQ)) begin
        idx_s = IDW'(rr_sum_s - (IDW+1)'(NUM_REQ));
      end else begin
        idx_s = IDW'(rr_sum_s);
      end
      if (credit_ok_s && !found_s && req_valid[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_id_s     = idx_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign req_ready = grant_s;
  assign issue_s   = found_s;
  assign tail_s    = slot_v_r[QPMM_LAT];

  // Round-robin pointer moves past the granted requester, holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r <= '0;
    end else if (issue_s) begin
      rr_ptr_r <= (grant_id_s == IDW'(NUM_REQ - 1)) ? IDW'(0) : grant_id_s + IDW'(1);
    end
  end

  // Operand registers toward the multiplier; idle cycles issue a zero bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_a_r <= '0;
      mm_b_r <= '0;
    end else if (issue_s) begin
      mm_a_r <= req_a[grant_id_s];
      mm_b_r <= req_b[grant_id_s];
    end else begin
      mm_a_r <= '0;
      mm_b_r <= '0;
    end
  end

  // In-flight tracker: valid/id/tag march in step with the multiplier pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_v_r <= '0;
      for (int k = 0; k <= QPMM_LAT; k++) begin
        slot_m_r[k] <= '0;
      end
    end else begin
      slot_v_r    <= {slot_v_r[QPMM_LAT-1:0], issue_s};
      slot_m_r[0] <= issue_s ? meta_t'{id: grant_id_s, tag: req_tag[grant_id_s]} : meta_t'('0);
      for (int k = 1; k <= QPMM_LAT; k++) begin
        slot_m_r[k] <= slot_m_r[k-1];
      end
    end
  end

  // In-flight count: up on issue, down when a result leaves the tracker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_r <= '0;
    end else begin
      case ({issue_s, tail_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign push_data_s = entry_t'{z: mm_z, id: slot_m_r[QPMM_LAT].id, tag: slot_m_r[QPMM_LAT].tag};
  assign pop_s       = res_valid && res_ready;

  qpmm_res_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (tail_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .valid     (res_valid),
    .count     (fifo_cnt_s)
  );

  assign mm_a    = mm_a_r;
  assign mm_b    = mm_b_r;
  assign res_z   = head_s.z;
  assign res_id  = head_s.id;
  assign res_tag = head_s.tag;
  assign busy    = (inflight_r != CW'(0)) || (fifo_cnt_s != CW'(0)) || (|req_valid);

endmodule

// File: tb/tb_qpmm_sched.sv
// Self-checking bench for qpmm_sched with a delay-line multiplier stub
// (mm_z = mm_a + mm_b, QPMM_LAT cycles later) and a queue-based reference model.
module tb_qpmm_sched;
  import qpmm_sched_pkg::*;

  localparam int NR = 4;
  localparam int FD = 8;
  localparam int L  = QPMM_LATENCY;

  logic           clk;
  logic           rstn;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  qpmm_fp_t       req_a   [NR];
  qpmm_fp_t       req_b   [NR];
  logic [3:0]     req_tag [NR];
  qpmm_fp_t       mm_a, mm_b, mm_z;
  logic           res_valid, res_ready;
  qpmm_fp_t       res_z;
  logic [1:0]     res_id;
  logic [3:0]     res_tag;
  logic           busy;

  qpmm_sched #(.NUM_REQ(NR), .QPMM_LAT(L), .TAG_W(4), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .mm_a(mm_a), .mm_b(mm_b),
    .mm_z(mm_z), .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
    .res_id(res_id), .res_tag(res_tag), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stub: sum of operands, delayed by L cycles.
  qpmm_fp_t pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mm_a + mm_b;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mm_z = pipe[L-1];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: results become visible L+2 cycles after their handshake,
  // leave in handshake order, and occupancy is bounded by FD.
  typedef struct {
    logic [255:0] z;
    int           id;
    logic [3:0]   tag;
    longint       arrive;
  } item_t;
  item_t    pend_q[$];
  item_t    fifo_q[$];
  int       rr_m = 0;
  int       g_last = -1;
  qpmm_fp_t exp_mm_a = '0, exp_mm_b = '0;

  logic [NR-1:0] s_req_ready;
  logic          s_res_valid, s_busy;
  qpmm_fp_t      s_res_z;
  logic [1:0]    s_res_id;
  logic [3:0]    s_res_tag;

  function automatic qpmm_fp_t rnd_fp();
    qpmm_fp_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic refresh(input int i);
    req_a[i] = rnd_fp();
    req_b[i] = rnd_fp();
    req_tag[i] = 4'($urandom_range(0, 15));
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (((v >> i) & 4'd1) != 4'd0) r = i;
    return r;
  endfunction

  // One clock cycle: sample mid-cycle, compare with the model, advance the model.
  task automatic check_cycle();
    int            g;
    int            i;
    logic [NR-1:0] er;
    qpmm_fp_t      na, nb;
    item_t         it;
    @(negedge clk);
    s_req_ready = req_ready; s_res_valid = res_valid; s_busy = busy;
    s_res_z = res_z; s_res_id = res_id; s_res_tag = res_tag;
    while (pend_q.size() > 0 && pend_q[0].arrive <= cyc) fifo_q.push_back(pend_q.pop_front());
    g = -1;
    if (pend_q.size() + fifo_q.size() < FD) begin
      for (int k = 0; k < NR; k++) begin
        i = (rr_m + k) % NR;
        if (g < 0 && ((req_valid >> i) & 4'd1) != 4'd0) g = i;
      end
    end
    er = '0;
    if (g >= 0) er = 4'd1 << g;
    chk("req_ready", 256'(req_ready), 256'(er));
    chk("mm_a", mm_a, exp_mm_a);
    chk("mm_b", mm_b, exp_mm_b);
    chk("res_valid", 256'(res_valid), 256'(fifo_q.size() != 0));
    if (fifo_q.size() > 0) begin
      chk("res_z", res_z, fifo_q[0].z);
      chk("res_id", 256'(res_id), 256'(fifo_q[0].id));
      chk("res_tag", 256'(res_tag), 256'(fifo_q[0].tag));
    end else begin
      chk("res_z_idle", res_z, 256'd0);
    end
    chk("busy", 256'(busy), 256'((pend_q.size() + fifo_q.size() != 0) || (req_valid != 4'd0)));
    na = '0; nb = '0;
    if (g >= 0) begin
      it.z = req_a[g] + req_b[g]; it.id = g; it.tag = req_tag[g]; it.arrive = cyc + L + 2;
      pend_q.push_back(it);
      rr_m = (g + 1) % NR;
      na = req_a[g]; nb = req_b[g];
    end
    if (res_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
    g_last = g;
    @(posedge clk); #1;
    exp_mm_a = na; exp_mm_b = nb;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; res_ready = 1'b0;
    @(negedge clk);
    chk("rst_mm_a", mm_a, 256'd0);
    chk("rst_mm_b", mm_b, 256'd0);
    chk("rst_req_ready", 256'(req_ready), 256'd0);
    chk("rst_res_valid", 256'(res_valid), 256'd0);
    chk("rst_res_z", res_z, 256'd0);
    chk("rst_res_id", 256'(res_id), 256'd0);
    chk("rst_res_tag", 256'(res_tag), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    pend_q.delete(); fifo_q.delete();
    rr_m = 0; g_last = -1; exp_mm_a = '0; exp_mm_b = '0;
  endtask

  task automatic drain();
    req_valid = '0; res_ready = 1'b1;
    for (int n = 0; n < L + 20; n++) check_cycle();
    chk("drain_busy", 256'(s_busy), 256'd0);
  endtask

  typedef struct {
    int           idx;
    logic [255:0] a;
    logic [255:0] b;
    logic [3:0]   tag;
    logic [255:0] exp_z;
    int           exp_id;
  } vec_t;
  vec_t vecs[4];
  int   rr_exp[6];

  initial begin
    int cnt, lat, seen;
    vecs[0] = '{2, 256'd5, 256'd7, 4'd3, 256'd12, 2};
    vecs[1] = '{0, {256{1'b1}}, 256'd1, 4'hF, 256'd0, 0};
    vecs[2] = '{1, 256'h100, 256'h0FF, 4'h9, 256'h1FF, 1};
    vecs[3] = '{3, 256'hFFFF_FFFF, 256'h1, 4'hA, 256'h1_0000_0000, 3};
    rr_exp  = '{0, 1, 2, 3, 0, 1};
    rstn = 1'b1; req_valid = '0; res_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin req_a[i] = '0; req_b[i] = '0; req_tag[i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // Single requests: latency, payload, busy after pop.
    for (int v = 0; v < 4; v++) begin
      req_a[vecs[v].idx] = vecs[v].a; req_b[vecs[v].idx] = vecs[v].b; req_tag[vecs[v].idx] = vecs[v].tag;
      req_valid = 4'd1 << vecs[v].idx;
      check_cycle();
      chk("single_grant", 256'(s_req_ready), 256'(4'd1 << vecs[v].idx));
      req_valid = '0;
      lat = -1;
      for (int n = 1; n <= L + 10; n++) begin
        check_cycle();
        if (s_res_valid) begin lat = n; break; end
      end
      chk("single_latency", 256'(lat), 256'(L + 2));
      chk("single_z", s_res_z, vecs[v].exp_z);
      chk("single_id", 256'(s_res_id), 256'(vecs[v].exp_id));
      chk("single_tag", 256'(s_res_tag), 256'(vecs[v].tag));
      res_ready = 1'b1; check_cycle(); res_ready = 1'b0;
      check_cycle();
      chk("single_busy_after_pop", 256'(s_busy), 256'd0);
    end

    // Round-robin with all requesters valid.
    do_reset();
    res_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < NR; i++) refresh(i);
    for (int n = 0; n < 6; n++) begin
      check_cycle();
      chk("rr_order", 256'(onehot_idx(s_req_ready)), 256'(rr_exp[n]));
      if (g_last >= 0) refresh(g_last);
    end
    drain();

    // Backpressure: credit stops at FD grants, resumes one cycle after the first pop.
    do_reset();
    req_valid = 4'd1; refresh(0); cnt = 0;
    for (int n = 0; n < L + 20; n++) begin
      check_cycle();
      if (s_req_ready[0]) begin cnt++; refresh(0); end
    end
    chk("bp_grants", 256'(cnt), 256'(FD));
    res_ready = 1'b1;
    check_cycle();
    chk("bp_pop_cycle_ready", 256'(s_req_ready), 256'd0);
    check_cycle();
    chk("bp_resume_ready", 256'(s_req_ready), 256'd1);
    drain();

    // Push and pop together with seven entries buffered.
    do_reset();
    req_valid = 4'd1; refresh(0); cnt = 0;
    for (int n = 0; n < 20 && cnt < 7; n++) begin
      check_cycle();
      if (s_req_ready[0]) begin cnt++; refresh(0); end
    end
    req_valid = '0;
    for (int n = 0; n < L + 5; n++) check_cycle();
    req_valid = 4'd1;
    check_cycle();
    chk("sim_eighth_grant", 256'(s_req_ready), 256'd1);
    req_valid = '0;
    for (int n = 0; n < L; n++) check_cycle();
    res_ready = 1'b1; check_cycle(); res_ready = 1'b0;
    check_cycle();
    res_ready = 1'b1; seen = 0;
    for (int n = 0; n < 12; n++) begin check_cycle(); if (s_res_valid) seen++; end
    chk("sim_remaining_entries", 256'(seen), 256'd7);
    drain();

    // Reset while five requests are in flight.
    do_reset();
    req_valid = 4'hF; res_ready = 1'b1; cnt = 0;
    for (int i = 0; i < NR; i++) refresh(i);
    for (int n = 0; n < 20 && cnt < 5; n++) begin
      check_cycle();
      if (g_last >= 0) begin cnt++; refresh(g_last); end
    end
    req_valid = '0;
    for (int n = 0; n < 10; n++) check_cycle();
    do_reset();
    res_ready = 1'b1; seen = 0;
    for (int n = 0; n < L + 10; n++) begin check_cycle(); if (s_res_valid) seen++; end
    chk("rst_no_results", 256'(seen), 256'd0);
    req_valid = 4'hF;
    check_cycle();
    chk("rst_rr_ptr", 256'(s_req_ready), 256'd1);
    drain();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (g_last == i) begin
          req_valid[i] = 1'($urandom_range(0, 1)); refresh(i);
        end else if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) == 0); refresh(i);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      check_cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
